// File: rtl/l2_burst_adaptor_if.sv
// l2_burst_adaptor_if: arbiter line port and memory burst port of the L2 burst adaptor
interface l2_burst_adaptor_if #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
);
    logic                 read_L2;
    logic                 write_L2;
    logic [31:0]          addr_L2;
    logic [LINE_BITS-1:0] wdata_L2;
    logic [LINE_BITS-1:0] rdata_L2;
    logic                 resp_L2;
    logic [31:0]          address_o;
    logic                 read_o;
    logic                 write_o;
    logic [BEAT_BITS-1:0] burst_o;
    logic [BEAT_BITS-1:0] burst_i;
    logic                 resp_i;

    modport slave (
        input  read_L2, write_L2, addr_L2, wdata_L2, burst_i, resp_i,
        output rdata_L2, resp_L2, address_o, read_o, write_o, burst_o
    );

    modport master (
        output read_L2, write_L2, addr_L2, wdata_L2, burst_i, resp_i,
        input  rdata_L2, resp_L2, address_o, read_o, write_o, burst_o
    );
endinterface

// File: rtl/l2_burst_adaptor.sv
// l2_burst_adaptor: turns one cache-line read/write into a 4-beat memory burst; L2_BURST_ADAPTOR_ASSERT_EN compiles in protocol checks
module l2_burst_adaptor #(
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64
) (
    input logic               clk,
    input logic               rst,
    l2_burst_adaptor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t               state, state_nxt;
    logic [1:0]           cnt;
    logic [31:0]          addr_q;
    logic [LINE_BITS-1:0] wline;
    logic [LINE_BITS-1:0] rbuf;
    logic [LINE_BITS-1:0] rdata;
    logic [LINE_BITS-1:0] fill;
    logic                 last;

    assign last = bus.resp_i && cnt == 2'd3;

    // state register; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nxt;

    // next state: write wins over read, DONE never samples requests
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.write_L2 ? WR : bus.read_L2 ? RD : IDLE;
            RD, WR:  state_nxt = last ? DONE : state;
            default: state_nxt = IDLE;
        endcase
    end

    // read buffer with the incoming beat merged into its slot
    always_comb begin
        fill = rbuf;
        fill[int'(cnt)*BEAT_BITS +: BEAT_BITS] = bus.burst_i;
    end

    // request capture, beat counting and read-line assembly
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt    <= '0;
            addr_q <= '0;
            wline  <= '0;
            rbuf   <= '0;
            rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.write_L2) begin
                        wline  <= bus.wdata_L2;
                        addr_q <= bus.addr_L2 & ~32'h1f;
                    end else if (bus.read_L2) begin
                        addr_q <= bus.addr_L2 & ~32'h1f;
                    end
                end
                RD: if (bus.resp_i) begin
                    cnt  <= cnt + 2'd1;
                    rbuf <= fill;
                    if (last) rdata <= fill;
                end
                WR: if (bus.resp_i) cnt <= cnt + 2'd1;
                default: ;
            endcase
        end

    assign bus.read_o    = state == RD;
    assign bus.write_o   = state == WR;
    assign bus.resp_L2   = state == DONE;
    assign bus.address_o = addr_q;
    assign bus.rdata_L2  = rdata;
    assign bus.burst_o   = state == WR ? wline[int'(cnt)*BEAT_BITS +: BEAT_BITS] : '0;

`ifdef L2_BURST_ADAPTOR_ASSERT_EN
    a_both_req: assert property (@(posedge clk) disable iff (!rst)
        !(state == IDLE && bus.read_L2 && bus.write_L2))
        else $error("read_L2 and write_L2 both high in IDLE");
    a_stray_resp: assert property (@(posedge clk) disable iff (!rst)
        !((state == IDLE || state == DONE) && bus.resp_i))
        else $error("resp_i high outside a burst");
    a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        ((state == RD || state == WR) && $past(state == RD || state == WR) &&
         (bus.read_L2 || bus.write_L2)) |-> $stable(bus.addr_L2))
        else $error("addr_L2 changed during a held request");
    a_rw_excl: assert property (@(posedge clk) disable iff (!rst)
        !(bus.read_o && bus.write_o))
        else $error("read_o and write_o both high");
`endif
endmodule

// File: tb/tb_l2_burst_adaptor.sv
// tb_l2_burst_adaptor: directed checks of the L2 burst adaptor
module tb_l2_burst_adaptor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [255:0] last_read = '0;

    l2_burst_adaptor_if bus ();

    l2_burst_adaptor dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.read_L2 = 0; bus.write_L2 = 0; bus.addr_L2 = '0; bus.wdata_L2 = '0;
        bus.burst_i = '0; bus.resp_i = 0;
        rst = 0;
        tick(); tick();
        vectors++; if (bus.read_o !== 1'b0) begin miscompares++; $display("FAIL rst_read_o got %b exp 0", bus.read_o); end
        vectors++; if (bus.write_o !== 1'b0) begin miscompares++; $display("FAIL rst_write_o got %b exp 0", bus.write_o); end
        vectors++; if (bus.resp_L2 !== 1'b0) begin miscompares++; $display("FAIL rst_resp_L2 got %b exp 0", bus.resp_L2); end
        vectors++; if (bus.address_o !== 32'h0) begin miscompares++; $display("FAIL rst_address_o got %h exp 0", bus.address_o); end
        vectors++; if (bus.burst_o !== 64'h0) begin miscompares++; $display("FAIL rst_burst_o got %h exp 0", bus.burst_o); end
        vectors++; if (bus.rdata_L2 !== 256'h0) begin miscompares++; $display("FAIL rst_rdata got %h exp 0", bus.rdata_L2); end
        rst = 1;
        tick();
    endtask

    task automatic test_read();
        logic [255:0] exp = {64'h3, 64'h2, 64'h1, 64'h0};
        bus.read_L2 = 1; bus.addr_L2 = 32'h0000_1234;
        tick();
        vectors++; if (bus.read_o !== 1'b1) begin miscompares++; $display("FAIL rd_read_o got %b exp 1", bus.read_o); end
        vectors++; if (bus.write_o !== 1'b0) begin miscompares++; $display("FAIL rd_write_o got %b exp 0", bus.write_o); end
        vectors++; if (bus.address_o !== 32'h0000_1220) begin miscompares++; $display("FAIL rd_address got %h exp 00001220", bus.address_o); end
        for (int i = 0; i < 4; i++) begin
            bus.resp_i = 1; bus.burst_i = 64'(i);
            vectors++; if (bus.resp_L2 !== 1'b0) begin miscompares++; $display("FAIL rd_early_resp beat %0d got %b exp 0", i, bus.resp_L2); end
            tick();
        end
        bus.resp_i = 0;
        vectors++; if (bus.resp_L2 !== 1'b1) begin miscompares++; $display("FAIL rd_resp_L2 got %b exp 1", bus.resp_L2); end
        vectors++; if (bus.read_o !== 1'b0) begin miscompares++; $display("FAIL rd_read_o_done got %b exp 0", bus.read_o); end
        vectors++; if (bus.rdata_L2 !== exp) begin miscompares++; $display("FAIL rd_rdata got %h exp %h", bus.rdata_L2, exp); end
        bus.read_L2 = 0;
        tick();
        vectors++; if (bus.resp_L2 !== 1'b0) begin miscompares++; $display("FAIL rd_resp_pulse got %b exp 0", bus.resp_L2); end
        last_read = exp;
    endtask

    task automatic test_write();
        logic [63:0] wb [4] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                                64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
        bus.write_L2 = 1; bus.addr_L2 = 32'hABCD_EF1F;
        bus.wdata_L2 = {wb[3], wb[2], wb[1], wb[0]};
        tick();
        vectors++; if (bus.write_o !== 1'b1) begin miscompares++; $display("FAIL wr_write_o got %b exp 1", bus.write_o); end
        vectors++; if (bus.address_o !== 32'hABCD_EF00) begin miscompares++; $display("FAIL wr_address got %h exp abcdef00", bus.address_o); end
        bus.addr_L2 = 32'h1111_1111; bus.wdata_L2 = '1;
        for (int i = 0; i < 4; i++) begin
            bus.resp_i = 1;
            vectors++; if (bus.burst_o !== wb[i]) begin miscompares++; $display("FAIL wr_beat%0d got %h exp %h", i, bus.burst_o, wb[i]); end
            vectors++; if (bus.address_o !== 32'hABCD_EF00) begin miscompares++; $display("FAIL wr_addr_stable beat %0d got %h exp abcdef00", i, bus.address_o); end
            tick();
        end
        bus.resp_i = 0;
        vectors++; if (bus.write_o !== 1'b0) begin miscompares++; $display("FAIL wr_write_o_done got %b exp 0", bus.write_o); end
        vectors++; if (bus.resp_L2 !== 1'b1) begin miscompares++; $display("FAIL wr_resp_L2 got %b exp 1", bus.resp_L2); end
        vectors++; if (bus.rdata_L2 !== last_read) begin miscompares++; $display("FAIL wr_rdata_kept got %h exp %h", bus.rdata_L2, last_read); end
        bus.write_L2 = 0;
        tick();
        vectors++; if (bus.resp_L2 !== 1'b0) begin miscompares++; $display("FAIL wr_resp_pulse got %b exp 0", bus.resp_L2); end
        vectors++; if (bus.burst_o !== 64'h0) begin miscompares++; $display("FAIL wr_burst_idle got %h exp 0", bus.burst_o); end
    endtask

    task automatic test_gapped();
        int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [255:0] exp = {64'h1006, 64'h1004, 64'h1003, 64'h1000};
        bus.read_L2 = 1; bus.addr_L2 = 32'h8000_00FF;
        tick();
        vectors++; if (bus.address_o !== 32'h8000_00E0) begin miscompares++; $display("FAIL gap_address got %h exp 800000e0", bus.address_o); end
        for (int j = 0; j < 7; j++) begin
            bus.resp_i = pat[j][0]; bus.burst_i = 64'h1000 + 64'(j);
            vectors++; if (bus.read_o !== 1'b1) begin miscompares++; $display("FAIL gap_read_o cycle %0d got %b exp 1", j, bus.read_o); end
            vectors++; if (bus.resp_L2 !== 1'b0) begin miscompares++; $display("FAIL gap_early_resp cycle %0d got %b exp 0", j, bus.resp_L2); end
            tick();
        end
        bus.resp_i = 0;
        vectors++; if (bus.resp_L2 !== 1'b1) begin miscompares++; $display("FAIL gap_resp_L2 got %b exp 1", bus.resp_L2); end
        vectors++; if (bus.rdata_L2 !== exp) begin miscompares++; $display("FAIL gap_rdata got %h exp %h", bus.rdata_L2, exp); end
        bus.read_L2 = 0;
        tick();
        last_read = exp;
    endtask

    task automatic test_idle_resp();
        bus.resp_i = 1; bus.burst_i = 64'hDEAD;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if ({bus.read_o, bus.write_o, bus.resp_L2} !== 3'b000) begin miscompares++; $display("FAIL idle_resp cycle %0d got %b exp 000", k, {bus.read_o, bus.write_o, bus.resp_L2}); end
        end
        bus.resp_i = 0;
    endtask

    task automatic test_back_to_back();
        logic [255:0] exp = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        bus.read_L2 = 1; bus.addr_L2 = 32'h0000_0040;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.resp_i = 1; bus.burst_i = 64'hA0 + 64'(i);
            tick();
        end
        bus.resp_i = 0;
        vectors++; if (bus.resp_L2 !== 1'b1) begin miscompares++; $display("FAIL b2b_read_resp got %b exp 1", bus.resp_L2); end
        tick();
        vectors++; if ({bus.read_o, bus.write_o, bus.resp_L2} !== 3'b000) begin miscompares++; $display("FAIL b2b_no_dup got %b exp 000", {bus.read_o, bus.write_o, bus.resp_L2}); end
        bus.read_L2 = 0;
        tick();
        bus.write_L2 = 1; bus.addr_L2 = 32'h0000_0080; bus.wdata_L2 = {64{4'h5}};
        tick();
        vectors++; if (bus.write_o !== 1'b1) begin miscompares++; $display("FAIL b2b_write_start got %b exp 1", bus.write_o); end
        for (int i = 0; i < 4; i++) begin
            bus.resp_i = 1;
            tick();
        end
        bus.resp_i = 0;
        vectors++; if (bus.resp_L2 !== 1'b1) begin miscompares++; $display("FAIL b2b_write_resp got %b exp 1", bus.resp_L2); end
        vectors++; if (bus.rdata_L2 !== exp) begin miscompares++; $display("FAIL b2b_rdata got %h exp %h", bus.rdata_L2, exp); end
        bus.write_L2 = 0;
        tick();
        last_read = exp;
    endtask

    task automatic test_reset_mid();
        logic [255:0] exp = {64'h44, 64'h33, 64'h22, 64'h11};
        bus.read_L2 = 1; bus.addr_L2 = 32'h0000_0100;
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.resp_i = 1; bus.burst_i = 64'h77 + 64'(i);
            tick();
        end
        bus.resp_i = 0; bus.read_L2 = 0;
        rst = 0;
        #1;
        vectors++; if (bus.read_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_read_o got %b exp 0", bus.read_o); end
        vectors++; if (bus.resp_L2 !== 1'b0) begin miscompares++; $display("FAIL mid_rst_resp got %b exp 0", bus.resp_L2); end
        vectors++; if (bus.rdata_L2 !== 256'h0) begin miscompares++; $display("FAIL mid_rst_rdata got %h exp 0", bus.rdata_L2); end
        tick();
        vectors++; if (bus.resp_L2 !== 1'b0) begin miscompares++; $display("FAIL mid_rst_no_resp got %b exp 0", bus.resp_L2); end
        rst = 1;
        tick();
        bus.read_L2 = 1; bus.addr_L2 = 32'h0000_0200;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.resp_i = 1; bus.burst_i = 64'h11 * 64'(i + 1);
            tick();
        end
        bus.resp_i = 0;
        vectors++; if (bus.resp_L2 !== 1'b1) begin miscompares++; $display("FAIL post_rst_resp got %b exp 1", bus.resp_L2); end
        vectors++; if (bus.rdata_L2 !== exp) begin miscompares++; $display("FAIL post_rst_rdata got %h exp %h", bus.rdata_L2, exp); end
        bus.read_L2 = 0;
        tick();
        last_read = exp;
    endtask

    task automatic test_both_req();
        logic [63:0] wb [4] = '{64'h0123_4567_89AB_CDEF, 64'h1, 64'hFFFF_0000_FFFF_0000, 64'h8000_0000_0000_0001};
        bus.read_L2 = 1; bus.write_L2 = 1; bus.addr_L2 = 32'h0000_0300;
        bus.wdata_L2 = {wb[3], wb[2], wb[1], wb[0]};
        tick();
        vectors++; if ({bus.read_o, bus.write_o} !== 2'b01) begin miscompares++; $display("FAIL both_rw got %b exp 01", {bus.read_o, bus.write_o}); end
        for (int i = 0; i < 4; i++) begin
            bus.resp_i = 1;
            vectors++; if (bus.burst_o !== wb[i]) begin miscompares++; $display("FAIL both_beat%0d got %h exp %h", i, bus.burst_o, wb[i]); end
            tick();
        end
        bus.resp_i = 0;
        vectors++; if (bus.resp_L2 !== 1'b1) begin miscompares++; $display("FAIL both_resp got %b exp 1", bus.resp_L2); end
        vectors++; if (bus.rdata_L2 !== last_read) begin miscompares++; $display("FAIL both_rdata got %h exp %h", bus.rdata_L2, last_read); end
        bus.read_L2 = 0; bus.write_L2 = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_gapped();
        test_idle_resp();
        test_back_to_back();
        test_reset_mid();
        test_both_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without completing, vectors %0d", vectors);
        $fatal(1, "timeout");
    end
endmodule
